// File: rtl/sram_boot_loader.sv
// Boot loader: copies BOOT_WORDS words from the boot ROM into SRAM, then releases the CPU and
// passes its instruction bus through. Define SRAM_BOOT_LOADER_VERIFY_EN to add read-back verify.
module sram_boot_loader #(
   parameter int DATA_W      = 32,
   parameter int SRAM_ADDR_W = 15,
   parameter int ROM_ADDR_W  = 10,
   parameter int BOOT_WORDS  = 1024
) (
   input  logic                     clk_i,
   input  logic                     cke_i,
   input  logic                     rst_i,
   output logic                     rom_en_o,
   output logic [ROM_ADDR_W-1:0]    rom_addr_o,
   input  logic [DATA_W-1:0]        rom_rdata_i,
   output logic                     i_avalid_o,
   output logic [SRAM_ADDR_W-3:0]   i_addr_o,
   output logic [DATA_W-1:0]        i_wdata_o,
   output logic [DATA_W/8-1:0]      i_wstrb_o,
   input  logic [DATA_W-1:0]        i_rdata_i,
   input  logic                     i_rvalid_i,
   input  logic                     i_ready_i,
   input  logic                     cpu_i_avalid_i,
   input  logic [SRAM_ADDR_W-3:0]   cpu_i_addr_i,
   output logic [DATA_W-1:0]        cpu_i_rdata_o,
   output logic                     cpu_i_rvalid_o,
   output logic                     cpu_i_ready_o,
   output logic                     cpu_rst_o,
   output logic                     boot_done_o,
   output logic                     boot_err_o
);
   localparam int WA_W  = SRAM_ADDR_W - 2;
   localparam int CNT_W = $clog2(BOOT_WORDS + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BOOT_WORDS - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ROM_RD = 3'd1,
      WR     = 3'd2,
`ifdef SRAM_BOOT_LOADER_VERIFY_EN
      V_ROM  = 3'd3,
      V_REQ  = 3'd4,
      V_WAIT = 3'd5,
`endif
      DONE   = 3'd6
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rom_en_q, rom_en_d;
   logic             cpu_rst_q, cpu_rst_d;
   logic             done_q, done_d;
   logic             err_d;
   logic             pass_en;

   // State register together with the counter and the registered outputs.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rom_en_q  <= 1'b0;
         cpu_rst_q <= 1'b1;
         done_q    <= 1'b0;
      end else if (cke_i) begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rom_en_q  <= rom_en_d;
         cpu_rst_q <= cpu_rst_d;
         done_q    <= done_d;
      end
   end

`ifdef SRAM_BOOT_LOADER_VERIFY_EN
   logic              err_q;
   logic              ref_ld_q;
   logic [DATA_W-1:0] ref_q;

   // The ROM word appears on the first V_REQ cycle and is held in ref_q across SRAM stalls.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_q    <= 1'b0;
         ref_ld_q <= 1'b0;
         ref_q    <= '0;
      end else if (cke_i) begin
         err_q    <= err_d;
         ref_ld_q <= (state_q == V_ROM);
         if (state_q == V_REQ && ref_ld_q) ref_q <= rom_rdata_i;
      end
   end

   assign err_d      = err_q | ((state_q == V_WAIT) && i_rvalid_i && (i_rdata_i != ref_q));
   assign boot_err_o = err_q;
`else
   assign err_d      = 1'b0;
   assign boot_err_o = 1'b0;
`endif

   // Next-state logic.
   always_comb begin
      // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE:   state_d = ROM_RD;
         ROM_RD: state_d = WR;
         WR: begin
            if (i_ready_i) begin
               if (cnt_q == LAST) begin
                  cnt_d = '0;
`ifdef SRAM_BOOT_LOADER_VERIFY_EN
                  state_d = V_ROM;
`else
                  state_d = DONE;
`endif
               end else begin
                  cnt_d   = cnt_q + CNT_W'(1);
                  state_d = ROM_RD;
               end
            end
         end
`ifdef SRAM_BOOT_LOADER_VERIFY_EN
         V_ROM: state_d = V_REQ;
         V_REQ: if (i_ready_i) state_d = V_WAIT;
         V_WAIT: begin
            if (i_rvalid_i) begin
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  state_d = DONE;
               end else begin
                  cnt_d   = cnt_q + CNT_W'(1);
                  state_d = V_ROM;
               end
            end
         end
`endif
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // Registered outputs change in the same edge that enters their state.
`ifdef SRAM_BOOT_LOADER_VERIFY_EN
   assign rom_en_d = (state_d == ROM_RD) || (state_d == V_ROM);
`else
   assign rom_en_d = (state_d == ROM_RD);
`endif
   assign cpu_rst_d = !((state_d == DONE) && !err_d);
   assign done_d    = (state_d == DONE);

   assign rom_en_o    = rom_en_q;
   assign cpu_rst_o   = cpu_rst_q;
   assign boot_done_o = done_q;
   assign rom_addr_o  = ROM_ADDR_W'(cnt_q);
   assign pass_en     = (state_q == DONE) && !boot_err_o;

   // Output logic: boot-mode SRAM drive, or CPU pass-through once booted cleanly.
   always_comb begin
      i_avalid_o     = 1'b0;
      i_addr_o       = WA_W'(cnt_q);
      i_wdata_o      = '0;
      i_wstrb_o      = '0;
      cpu_i_rdata_o  = '0;
      cpu_i_rvalid_o = 1'b0;
      cpu_i_ready_o  = 1'b0;
      if (pass_en) begin
         i_avalid_o     = cpu_i_avalid_i;
         i_addr_o       = cpu_i_addr_i;
         cpu_i_rdata_o  = i_rdata_i;
         cpu_i_rvalid_o = i_rvalid_i;
         cpu_i_ready_o  = i_ready_i;
      end else if (state_q == WR) begin
         i_avalid_o = 1'b1;
         i_wdata_o  = rom_rdata_i;
         i_wstrb_o  = '1;
      end
`ifdef SRAM_BOOT_LOADER_VERIFY_EN
      else if (state_q == V_REQ) begin
         i_avalid_o = 1'b1;
      end
`endif
   end
endmodule

// File: doc/sram_boot_loader.md
Name: sram_boot_loader

Overview:
- Upstream stage of the SoC SUT main SRAM. It drives the SRAM instruction port, which is the port that carries the boot write path.
- After reset it holds the CPU in reset and copies BOOT_WORDS firmware words from a boot ROM into SRAM word addresses 0..BOOT_WORDS-1.
- When the copy completes it releases the CPU and passes the CPU instruction bus through to SRAM.
- Optional read-back verification of the copied image.

Parameters:
- DATA_W, 32: data word width; DATA_W/8 strobe bits.
- SRAM_ADDR_W, 15: SRAM byte address width. Word address width is SRAM_ADDR_W-2.
- ROM_ADDR_W, 10: boot ROM word address width.
- BOOT_WORDS, 1024: words to copy. Legal range is 1..min(2^ROM_ADDR_W, 2^(SRAM_ADDR_W-2)).

Ports:
- clk_i  in  1  system clock; one clock domain only
- cke_i  in  1  clock enable; when 0, all state holds
- rst_i  in  1  reset; synchronous, active-high
- rom_en_o  out  1  ROM read enable; ROM returns rom_rdata_i one cycle later
- rom_addr_o  out  ROM_ADDR_W  ROM word address
- rom_rdata_i  in  DATA_W  ROM read data
- i_avalid_o  out  1  SRAM instruction port valid
- i_addr_o  out  SRAM_ADDR_W-2  SRAM word address
- i_wdata_o  out  DATA_W  SRAM write data
- i_wstrb_o  out  DATA_W/8  SRAM write strobe
- i_rdata_i  in  DATA_W  SRAM read data
- i_rvalid_i  in  1  SRAM read data valid; arrives one cycle after an accepted read
- i_ready_i  in  1  SRAM request accepted
- cpu_i_avalid_i  in  1  CPU instruction request
- cpu_i_addr_i  in  SRAM_ADDR_W-2  CPU instruction word address
- cpu_i_rdata_o  out  DATA_W  instruction data to CPU
- cpu_i_rvalid_o  out  1  instruction data valid to CPU
- cpu_i_ready_o  out  1  CPU request accepted
- cpu_rst_o  out  1  CPU reset, active-high
- boot_done_o  out  1  copy (and verify, if built) finished
- boot_err_o  out  1  sticky verify mismatch flag

Behaviour:
- Registered outputs (rom_en_o, cpu_rst_o, boot_done_o, boot_err_o) are updated on rising clk_i only when cke_i=1. The boot-mode SRAM drive is decoded from registered state.
- Reset values: cpu_rst_o=1, boot_done_o=0, boot_err_o=0, rom_en_o=0, i_avalid_o=0, i_wstrb_o=0, word counter=0, state=IDLE.
- FSM states: IDLE, ROM_RD, WR, then V_ROM, V_REQ, V_WAIT (verify build only), then DONE.
- IDLE: one cycle after reset is released, then go to ROM_RD.
- ROM_RD: rom_en_o=1, rom_addr_o=cnt. Next state is WR.
- WR: i_avalid_o=1, i_addr_o=cnt, i_wdata_o=rom_rdata_i, i_wstrb_o all ones.
  - Hold WR with the bus stable until i_ready_i=1.
  - On acceptance: if cnt==BOOT_WORDS-1, clear cnt and go to V_ROM (verify build) or DONE. Otherwise increment cnt and return to ROM_RD.
- Copy latency with i_ready_i held at 1: 2*BOOT_WORDS cycles from leaving IDLE. DONE is entered on the following edge.
- Write transactions never expect i_rvalid_i. Any i_rvalid_i seen during WR is ignored.
- DONE: cpu_rst_o=0 and boot_done_o=1 in the same cycle DONE is entered. Pass-through is active:
  - i_avalid_o=cpu_i_avalid_i, i_addr_o=cpu_i_addr_i, i_wdata_o=0, i_wstrb_o=0.
  - cpu_i_rdata_o=i_rdata_i, cpu_i_rvalid_o=i_rvalid_i, cpu_i_ready_o=i_ready_i.
  - All pass-through paths are combinational with zero added latency.
- Before DONE: cpu_i_ready_o=0, cpu_i_rvalid_o=0, cpu_i_rdata_o=0, and CPU requests are ignored.
- Counter width is ceil(log2(BOOT_WORDS+1)). rom_addr_o and i_addr_o are the zero-extended or truncated counter. There is no wrap; the terminal compare uses BOOT_WORDS-1.
- BOOT_WORDS=1: exactly one ROM_RD/WR pair.
- rst_i asserted mid-copy: the next edge returns to reset values, and the copy restarts at word 0 after release. Already-written SRAM words are simply overwritten.
- cke_i=0: FSM, counter and registered outputs freeze. Combinational outputs keep reflecting the frozen state.

Optional Feature:
- Macro: SRAM_BOOT_LOADER_VERIFY_EN.
- When defined, after the last write the block re-reads every word:
  - V_ROM: ROM read of cnt.
  - V_REQ: i_avalid_o=1, i_wstrb_o=0, i_addr_o=cnt; hold until i_ready_i=1. The ROM word is registered.
  - V_WAIT: wait for i_rvalid_i=1, then compare i_rdata_i with the registered ROM word. A mismatch sets boot_err_o (sticky until rst_i).
  - Then either increment cnt and go to V_ROM, or go to DONE after the last word.
- Verify with error: in DONE, boot_done_o=1 but cpu_rst_o stays 1 and pass-through stays disabled.
- Verify latency with ideal SRAM: 3*BOOT_WORDS cycles.
- When not defined: the verify states are absent, WR goes directly to DONE, and boot_err_o is tied to 0.

Test Plan:
- BOOT_WORDS=4, ROM={0x11111111,0x22222222,0x33333333,0x44444444}, i_ready_i=1 -> four SRAM writes, addrs 0..3, wstrb=0xF, matching data. boot_done_o and cpu_rst_o falling on cycle 9 after reset release.
- i_ready_i low for 3 cycles during the write of word 2 -> i_addr_o=2 and i_wdata_o=0x33333333 held stable for 4 cycles. Completion delayed by exactly 3 cycles.
- rst_i pulsed during the write of word 1 -> cpu_rst_o stays 1. Write sequence restarts at addr 0 and completes normally.
- After DONE, CPU reads addr 3 -> i_avalid_o mirrors cpu_i_avalid_i, i_wstrb_o=0. cpu_i_rdata_o=0x44444444 with cpu_i_rvalid_o one cycle later.
- VERIFY_EN, SRAM model corrupts word 1 readback to 0xDEADBEEF -> boot_err_o=1, boot_done_o=1, cpu_rst_o remains 1, cpu_i_ready_o=0.
- cke_i=0 for 5 cycles mid-copy -> no state change during those cycles. Total completion delayed by 5 cycles.
